// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin stream multiplexor family:
// default sizing, packet-lock FSM states and channel-index width helper.
package mux_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // A single channel still needs a 1-bit index so out_sel is never zero-width.
    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_rr_pick.sv
// Combinational round-robin picker: first valid channel at or after ptr,
// wrapping modulo CHANNELS so unused index codes are never produced.
module rr_pick
    import mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                any_valid
);

    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!any_valid && valid[idx]) begin
                any_valid = 1'b1;
                grant     = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb.sv
// Round-robin N:1 valid/ready multiplexor with one registered output stage.
// Define MUX_ARB_LAST_EN to add in_last/out_last and packet-granular locking.
module mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
`ifdef MUX_ARB_LAST_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel
);

    logic             load;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_any;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             xfer;
    logic             ends_pkt;

    assign load = !out_valid || out_ready;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_pick (
        .valid     (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .any_valid (rr_any)
    );

`ifdef MUX_ARB_LAST_EN
    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] lock_q, lock_d;

    // While locked the owner keeps in_ready even when idle, so a gap is a bubble, not a release.
    assign grant     = (state_q == LOCKED) ? lock_q : rr_grant;
    assign grant_vld = (state_q == LOCKED) ? 1'b1 : rr_any;
    assign ends_pkt  = in_last[grant];

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (xfer && !in_last[grant]) begin
                    state_d = LOCKED;
                    lock_d  = grant;
                end
            end
            LOCKED: begin
                if (xfer && in_last[grant]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end
`else
    assign grant     = rr_grant;
    assign grant_vld = rr_any;
    assign ends_pkt  = 1'b1;
`endif

    assign xfer = load && grant_vld && in_valid[grant];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = load && grant_vld && (grant == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (xfer && ends_pkt) begin
            ptr <= (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
`ifdef MUX_ARB_LAST_EN
            out_last  <= 1'b0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel   <= grant;
`ifdef MUX_ARB_LAST_EN
            out_last  <= in_last[grant];
`endif
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_arb.md
# mux_arb

Parametrised successor to the fixed 16-bit 2:1 word multiplexor. It selects one of CHANNELS valid/ready input streams of WIDTH bits using round-robin arbitration and drives the winner into a single registered output stage. It sits between multiple producers (register-file read ports, memory/IO masters) and one shared consumer. The output register gives full one-beat-per-cycle throughput with back-pressure.

## Interface
**Parameters**
- WIDTH, default 16: data width per channel.
- CHANNELS, default 4: number of input channels; must be ≥1, and need not be a power of two.
- SEL_W, default $clog2(CHANNELS) (minimum 1): width of the channel index.

**Ports**
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_valid, input, CHANNELS: per-channel data valid.
- in_ready, output, CHANNELS: per-channel accept.
- in_data, input, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- in_last, input, CHANNELS: end-of-packet marker. Present only with MUX_ARB_LAST_EN.
- out_valid, output, 1: output register holds a beat.
- out_ready, input, 1: consumer accepts the beat.
- out_data, output, WIDTH: registered selected data.
- out_sel, output, SEL_W: index of the channel that produced out_data.
- out_last, output, 1: registered in_last of the beat. Present only with MUX_ARB_LAST_EN.

## Operation
- **Reset values:** out_valid=0, out_data=0, out_sel=0, out_last=0, rr pointer=0, FSM=IDLE.
- **Load enable:** load = !out_valid || out_ready. It is combinational from out_valid and out_ready.
- **Grant:** grant is the first channel with in_valid=1, searching from rr pointer upward and wrapping modulo CHANNELS. If no channel is valid, there is no grant.
- **Input ready:** in_ready[i] = load && (i == grant). At most one bit of in_ready is high. in_ready does not depend on in_valid of other channels beyond the grant computation.
- **Input transfer:** occurs on channel g when in_valid[g] && in_ready[g]. On the next edge it sets out_valid=1, out_data=in_data[g], out_sel=g.
- **Output drain:** if load=1 and there is no transfer, out_valid becomes 0 and out_data/out_sel hold their values.
- **Pointer update:** the rr pointer becomes (g+1) mod CHANNELS after a transfer that ends a packet. Without the macro, every beat ends a packet. Wrap for a non-power-of-two CHANNELS must skip the unused index codes.
- **Single channel:** CHANNELS=1 degenerates to a one-stage registered pipe with out_sel constantly 0.

## Timing
- **Latency:** 1 cycle from input transfer to out_valid.
- **Throughput:** 1 beat per cycle while out_ready=1.
- **Simultaneous drain and load:** out_valid && out_ready on the same edge as a new input transfer replaces the beat with no bubble.
- **Output stability:** out_data, out_sel and out_last must stay stable while out_valid && !out_ready.
- **Reset assertion:** asserting reset mid-stream or mid-packet clears state immediately, independent of clk. Any in-flight beat and any packet lock are dropped.
- **Reset release:** first grant is evaluated from channel 0.

## Configuration
- **MUX_ARB_LAST_EN defined:** adds in_last and out_last plus a 2-state FSM.
  - IDLE: grant is computed by round-robin as above.
  - Transfer with in_last=0 in IDLE moves to LOCKED and captures lock channel = g.
  - LOCKED: grant is forced to the lock channel. Other channels see in_ready=0 even if they are valid. The locked channel with in_valid=0 leaves a bubble and does not release the lock.
  - Transfer with in_last=1 returns to IDLE and advances the rr pointer past the lock channel.
  - A transfer in IDLE with in_last=1 is a single-beat packet and stays in IDLE.
- **MUX_ARB_LAST_EN undefined:** no FSM, no last ports. Arbitration rotates every beat.

## Structure
- Shared package mux_pkg holds:
  - the default WIDTH/CHANNELS localparams;
  - the FSM state typedef (IDLE, LOCKED);
  - a function computing SEL_W.
- One sub-module, rr_pick. It is combinational and takes valid vector plus pointer to produce grant index and any_valid. It is reused by later arbiters.
- Output register, pointer and FSM stay in mux_arb.

## Test plan
- **Single channel:** CHANNELS=4, WIDTH=16, out_ready=1, only ch2 valid with data 0x1234 → in_ready=4'b0100; next cycle out_valid=1, out_data=0x1234, out_sel=2.
- **Fairness:** all four channels valid continuously, out_ready=1 → out_sel sequence 0,1,2,3,0,… with no idle cycles.
- **Back-pressure:** out_valid=1, out_data=0xBEEF, out_ready=0 for 3 cycles → in_ready=0 on all channels and out_data held at 0xBEEF. Raising out_ready gives a same-cycle refill with no bubble.
- **Non-power-of-two wrap:** CHANNELS=3, channels 0 and 2 valid → out_sel alternates 0,2,0,2; index 3 never appears.
- **Packet lock (MUX_ARB_LAST_EN):** ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch3 are valid, with a 1-cycle ch1 gap mid-packet → out_sel=1,1,1 with a bubble at the gap, then ch3, then ch0.
- **Async reset:** reset pulses between clock edges mid-packet → out_valid=0 and out_data=0 immediately. After release, the first grant goes to the lowest valid channel counting from 0.
